// File: rtl/mio_uart_pkg.sv
// mio_uart_pkg: register offsets, STATUS bit positions and shifter states for mio_uart_tx
package mio_uart_pkg;
  localparam logic [1:0] UART_DATA = 2'd0, UART_STATUS = 2'd1, UART_DIV = 2'd2, UART_CTRL = 2'd3;
  localparam int ST_BUSY = 0, ST_EMPTY = 1, ST_FULL = 2, ST_COUNT = 3, ST_OVF = 8;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
endpackage

// File: rtl/mio_uart_tx_sync_fifo.sv
// sync_fifo: synchronous FIFO; ports clk, rst, push/din, pop/dout, full, empty, count.
// A push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/mio_uart_tx.sv
// mio_uart_tx: MIO bus UART transmitter (register file, TX FIFO, baud counter, shifter).
// Ports: clk, rst (sync, active high); uart_we/uart_addr/uart_wdata bus write;
// uart_rdata combinational read; txd serial out (idle high); tx_irq idle-empty interrupt.
// Define UART_TX_PARITY_EN to add CTRL parity_en (bit2) / odd (bit3) and a parity bit.
module mio_uart_tx
  import mio_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_we,
  input  logic [1:0]  uart_addr,
  input  logic [31:0] uart_wdata,
  output logic [31:0] uart_rdata,
  output logic        txd,
  output logic        tx_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  state_t state, state_n;
  logic [15:0] div, div_lat, cnt;
  logic [7:0] sh, head;
  logic [2:0] idx;
  logic [AW:0] count;
  logic overflow, tx_en, irq_en, full, empty, busy, tick, pop, wr_data, par_on, par_bit;
  logic [31:0] ctrl_rd;
  logic unused;
  assign unused = ^uart_wdata[31:16];
  assign tick = cnt == 16'd0;
  assign busy = state != IDLE;
  assign wr_data = uart_we && uart_addr == UART_DATA;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(wr_data), .din(uart_wdata[7:0]), .pop(pop),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
`ifdef UART_TX_PARITY_EN
  logic par_en, odd, par_lat, par_en_lat;
  assign par_on = par_en_lat;
  assign par_bit = par_lat;
  assign ctrl_rd = {28'b0, odd, par_en, irq_en, tx_en};
  always_ff @(posedge clk)
    if (rst) begin
      par_en <= 1'b0;
      odd <= 1'b0;
      par_lat <= 1'b0;
      par_en_lat <= 1'b0;
    end else begin
      if (uart_we && uart_addr == UART_CTRL) begin
        par_en <= uart_wdata[2];
        odd <= uart_wdata[3];
      end
      if (pop) begin
        par_en_lat <= par_en;
        par_lat <= ^head ^ odd;
      end
    end
`else
  assign par_on = 1'b0;
  assign par_bit = 1'b1;
  assign ctrl_rd = {30'b0, irq_en, tx_en};
`endif
  assign txd = state == START ? 1'b0 : state == DATA ? sh[0] : state == PARITY ? par_bit : 1'b1;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE: if (tx_en && !empty) begin
        pop = 1'b1;
        state_n = START;
      end
      START: if (tick) state_n = DATA;
      DATA: if (tick && idx == 3'd7) state_n = par_on ? PARITY : STOP;
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_n = STOP;
`endif
      STOP: if (tick) begin
        pop = tx_en && !empty;
        state_n = pop ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb
    uart_rdata = uart_addr == UART_STATUS ? {23'b0, overflow, 5'(count), full, empty, busy} :
                 uart_addr == UART_DIV    ? {16'b0, div} :
                 uart_addr == UART_CTRL   ? ctrl_rd : 32'b0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      div <= DIV_RESET;
      div_lat <= 16'd0;
      cnt <= 16'd0;
      sh <= 8'd0;
      idx <= 3'd0;
      overflow <= 1'b0;
      tx_en <= 1'b0;
      irq_en <= 1'b0;
      tx_irq <= 1'b0;
    end else begin
      state <= state_n;
      tx_irq <= empty && state == IDLE && irq_en;
      if (uart_we && uart_addr == UART_STATUS) overflow <= 1'b0;
      if (wr_data && full && !pop) overflow <= 1'b1;
      if (uart_we && uart_addr == UART_DIV) div <= uart_wdata[15:0];
      if (uart_we && uart_addr == UART_CTRL) begin
        tx_en <= uart_wdata[0];
        irq_en <= uart_wdata[1];
      end
      if (busy) cnt <= tick ? div_lat : cnt - 16'd1;
      if (state == DATA && tick) begin
        sh <= sh >> 1;
        idx <= idx + 3'd1;
      end
      // each frame runs on the divisor captured when its byte left the FIFO
      if (pop) begin
        div_lat <= div;
        cnt <= div;
        sh <= head;
        idx <= 3'd0;
      end
    end
endmodule

// File: tb/tb_mio_uart_tx.sv
// tb_mio_uart_tx: randomized self-checking bench for mio_uart_tx against a bit-stream model
module tb_mio_uart_tx;
  import mio_uart_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1, uart_we = 1'b0;
  logic [1:0] uart_addr = 2'd0;
  logic [31:0] uart_wdata = 32'd0;
  logic [31:0] uart_rdata;
  logic txd, tx_irq;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  mio_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd433)) dut (
    .clk(clk), .rst(rst), .uart_we(uart_we), .uart_addr(uart_addr),
    .uart_wdata(uart_wdata), .uart_rdata(uart_rdata), .txd(txd), .tx_irq(tx_irq)
  );
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    uart_we = 1'b1;
    uart_addr = a;
    uart_wdata = d;
    @(negedge clk);
    uart_we = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    uart_addr = a;
    #1;
    d = uart_rdata;
  endtask
  function automatic logic [31:0] stat(input bit ovf, input int n, input bit bsy);
    logic [4:0] c;
    c = 5'(n);
    return {23'b0, ovf, c, n == DEPTH, n == 0, bsy};
  endfunction
  task automatic expect_reg(input logic [1:0] a, input logic [31:0] want, input string name);
    logic [31:0] v;
    rd(a, v);
    checks++;
    if (v !== want) $display("FAIL %s: got %h want %h", name, v, want);
    else passed++;
  endtask
  task automatic check_stream(input logic [7:0] bytes[$], input int divs[$], input bit par,
                              input bit odd, input bit irq_exp, input bit chk_busy, input string name);
    int bad, bbad, ibad, pos, n;
    logic got, want;
    logic b[$];
    bbad = 0;
    ibad = 0;
    n = 0;
    if (chk_busy) begin
      uart_addr = UART_STATUS;
      #1;
    end
    checks++;
    if (txd !== 1'b1 || (chk_busy && uart_rdata[0] !== 1'b0))
      $display("FAIL %s lead: txd %b busy %b want 1 0", name, txd, uart_rdata[0]);
    else passed++;
    for (int f = 0; f < bytes.size(); f++) begin
      b = {};
      b.push_back(1'b0);
      for (int i = 0; i < 8; i++) b.push_back(bytes[f][i]);
      if (par) b.push_back(^bytes[f] ^ odd);
      b.push_back(1'b1);
      bad = 0;
      pos = 0;
      got = 1'b0;
      want = 1'b0;
      for (int k = 0; k < b.size(); k++)
        for (int r = 0; r <= divs[f]; r++) begin
          @(negedge clk);
          if (txd !== b[k]) begin
            if (bad == 0) begin
              got = txd;
              want = b[k];
              pos = n;
            end
            bad++;
          end
          if (chk_busy && uart_rdata[0] !== 1'b1) bbad++;
          if (tx_irq !== 1'b0) ibad++;
          n++;
        end
      checks++;
      if (bad != 0)
        $display("FAIL %s frame %0d (byte %h div %0d): txd got %b want %b at cycle %0d, %0d bad",
                 name, f, bytes[f], divs[f], got, want, pos, bad);
      else passed++;
    end
    if (chk_busy) begin
      checks++;
      if (bbad != 0) $display("FAIL %s busy: %0d cycles got 0 want 1", name, bbad);
      else passed++;
    end
    checks++;
    if (ibad != 0) $display("FAIL %s irq in frame: %0d cycles got 1 want 0", name, ibad);
    else passed++;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1 || tx_irq !== 1'b0 || (chk_busy && uart_rdata[0] !== 1'b0))
      $display("FAIL %s post idle: txd %b irq %b busy %b want 1 0 0", name, txd, tx_irq, uart_rdata[0]);
    else passed++;
    @(negedge clk);
    checks++;
    if (tx_irq !== irq_exp) $display("FAIL %s post irq: got %b want %b", name, tx_irq, irq_exp);
    else passed++;
  endtask
  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset idle txd: %0d cycles got 0 want 1", bad);
    else passed++;
    checks++;
    if (tx_irq !== 1'b0) $display("FAIL reset irq: got %b want 0", tx_irq);
    else passed++;
    expect_reg(UART_STATUS, 32'h2, "reset status");
    expect_reg(UART_DIV, 32'd433, "reset div");
    expect_reg(UART_CTRL, 32'd0, "reset ctrl");
  endtask
  task automatic test_basic();
    logic [7:0] q[$];
    int d[$];
    q = {8'h55};
    d = {3};
    wr(UART_DIV, 32'd3);
    wr(UART_CTRL, 32'd1);
    wr(UART_DATA, 32'h55);
    check_stream(q, d, 1'b0, 1'b0, 1'b0, 1'b1, "basic");
  endtask
  task automatic test_overflow();
    logic [7:0] q[$];
    int d[$];
    wr(UART_DIV, 32'd0);
    wr(UART_CTRL, 32'd0);
    for (int i = 1; i <= 9; i++) wr(UART_DATA, 32'(i));
    expect_reg(UART_STATUS, stat(1'b1, DEPTH, 1'b0), "overflow status");
    wr(UART_STATUS, 32'd0);
    expect_reg(UART_STATUS, stat(1'b0, DEPTH, 1'b0), "overflow cleared");
    for (int i = 1; i <= DEPTH; i++) begin
      q.push_back(8'(i));
      d.push_back(0);
    end
    wr(UART_CTRL, 32'd1);
    check_stream(q, d, 1'b0, 1'b0, 1'b0, 1'b1, "back_to_back");
    expect_reg(UART_STATUS, 32'h2, "drained status");
  endtask
  task automatic test_irq();
    logic [7:0] q[$];
    int d[$];
    q = {8'($urandom)};
    d = {1};
    wr(UART_DIV, 32'd1);
    wr(UART_CTRL, 32'd3);
    wr(UART_DATA, {24'd0, q[0]});
    check_stream(q, d, 1'b0, 1'b0, 1'b1, 1'b1, "irq");
    wr(UART_CTRL, 32'd1);
    @(negedge clk);
    checks++;
    if (tx_irq !== 1'b0) $display("FAIL irq disable: got %b want 0", tx_irq);
    else passed++;
  endtask
  task automatic test_div_change();
    logic [7:0] q[$];
    int d[$];
    q = {8'($urandom), 8'($urandom)};
    d = {1, 7};
    wr(UART_CTRL, 32'd0);
    wr(UART_DIV, 32'd1);
    wr(UART_DATA, {24'd0, q[0]});
    wr(UART_DATA, {24'd0, q[1]});
    wr(UART_CTRL, 32'd1);
    fork
      check_stream(q, d, 1'b0, 1'b0, 1'b0, 1'b0, "div_change");
      begin
        repeat (4) @(negedge clk);
        wr(UART_DIV, 32'd7);
      end
    join
  endtask
  task automatic test_txen_clear();
    logic [7:0] q[$], r[$];
    int d[$];
    q = {8'($urandom)};
    r = {8'($urandom)};
    d = {2};
    wr(UART_CTRL, 32'd0);
    wr(UART_DIV, 32'd2);
    wr(UART_DATA, {24'd0, q[0]});
    wr(UART_DATA, {24'd0, r[0]});
    wr(UART_CTRL, 32'd1);
    fork
      check_stream(q, d, 1'b0, 1'b0, 1'b0, 1'b0, "txen_clear");
      begin
        repeat (6) @(negedge clk);
        wr(UART_CTRL, 32'd0);
      end
    join
    expect_reg(UART_STATUS, stat(1'b0, 1, 1'b0), "txen_clear retained");
    wr(UART_CTRL, 32'd1);
    check_stream(r, d, 1'b0, 1'b0, 1'b0, 1'b1, "txen_resume");
  endtask
  task automatic test_random();
    logic [7:0] q[$];
    int d[$];
    int dv, n;
    for (int it = 0; it < 5; it++) begin
      q = {};
      d = {};
      dv = $urandom_range(0, 3);
      n = $urandom_range(1, 4);
      wr(UART_CTRL, 32'd0);
      wr(UART_DIV, 32'(dv));
      for (int i = 0; i < n; i++) begin
        q.push_back(8'($urandom));
        d.push_back(dv);
        wr(UART_DATA, {24'd0, q[i]});
      end
      expect_reg(UART_STATUS, stat(1'b0, n, 1'b0), "random fill");
      wr(UART_CTRL, 32'd1);
      check_stream(q, d, 1'b0, 1'b0, 1'b0, 1'b1, "random");
    end
  endtask
`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] q[$];
    int d[$];
    bit o;
    q = {8'h07};
    d = {1};
    wr(UART_DIV, 32'd1);
    wr(UART_CTRL, 32'h5);
    wr(UART_DATA, 32'h07);
    check_stream(q, d, 1'b1, 1'b0, 1'b0, 1'b1, "parity_even");
    o = 1'($urandom);
    q = {8'($urandom)};
    wr(UART_CTRL, {28'd0, o, 3'b101});
    wr(UART_DATA, {24'd0, q[0]});
    check_stream(q, d, 1'b1, o, 1'b0, 1'b1, "parity_rand");
  endtask
`endif
  task automatic test_reset_mid();
    wr(UART_DIV, 32'd3);
    wr(UART_CTRL, 32'd1);
    wr(UART_DATA, 32'h00);
    wr(UART_DATA, 32'h00);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (txd !== 1'b1) $display("FAIL reset_mid txd: got %b want 1", txd);
    else passed++;
    expect_reg(UART_STATUS, 32'h2, "reset_mid status");
    expect_reg(UART_DIV, 32'd433, "reset_mid div");
    expect_reg(UART_CTRL, 32'd0, "reset_mid ctrl");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_irq();
    test_div_change();
    test_txen_clear();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mio_uart_tx.md
Name: mio_uart_tx

Overview:
- Memory-mapped serial transmitter peripheral on the MIO bus, alongside the GPIO, counter and RAM ports decoded by the bus.
- The CPU writes bytes into a small TX FIFO; a bit-timer and shifter send them as 8N1 frames (8E1 with the optional feature) on `txd`.
- Status register is readable through the bus read mux; `tx_irq` can feed the CPU `INT` input when idle-empty.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.
- DIV_RESET, 16'd433, reset value of the baud divisor (100 MHz / 434 ≈ 230400 baud).

Ports:
- clk  input  1  system clock (same domain as the MIO bus)
- rst  input  1  synchronous, active-high reset
- uart_we  input  1  bus write strobe, already address-decoded to this peripheral
- uart_addr  input  2  word offset: 0 = DATA, 1 = STATUS, 2 = DIVISOR, 3 = CTRL
- uart_wdata  input  32  bus write data
- uart_rdata  output  32  combinational read data for `uart_addr`
- txd  output  1  serial line, idle high
- tx_irq  output  1  interrupt request: FIFO empty AND shifter idle AND CTRL.irq_en

Behaviour:
- Reset values:
  - txd = 1, tx_irq = 0.
  - FIFO empty, shifter IDLE, divisor = DIV_RESET.
  - CTRL = 0 (irq_en = 0, tx_en = 0), overflow = 0.
- Write DATA (offset 0):
  - `uart_wdata[7:0]` is pushed at the clk edge where `uart_we` = 1.
  - When the FIFO is full, the byte is dropped and sticky `overflow` is set.
  - FIFO contents are unchanged on overflow.
- Write STATUS (offset 1): any write clears `overflow`. It has no other effect.
- Write DIVISOR (offset 2):
  - Loads `uart_wdata[15:0]`.
  - Bit period = divisor+1 clk cycles; divisor 0 gives 1 cycle per bit.
  - A frame in progress keeps its latched divisor; the new value applies from the next frame.
- Write CTRL (offset 3): bit0 = tx_en, bit1 = irq_en.
- Read data (offset 2 and 3 reads return the register, zero-extended):
  - STATUS = {23'b0, overflow, count[4:0], full, empty, busy}.
  - busy = shifter not IDLE.
  - count = FIFO occupancy 0..FIFO_DEPTH.
  - Reads have no side effects.
- Shifter FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE/START.
  - IDLE: txd = 1. When tx_en = 1 and the FIFO is non-empty, pop the head and latch byte + divisor on that edge → START. txd goes 0 on the following cycle.
  - START: txd = 0 for one bit period → DATA.
  - DATA: LSB first; 8 bit periods; bit index 0..7 → STOP (or PARITY with the option).
  - STOP: txd = 1 for one bit period.
    - At its end, if tx_en = 1 and the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Frame length is exactly 10×(div+1) cycles (11× with parity), measured from the first txd low cycle to the first cycle of the next start bit.
- Simultaneous push and pop in one cycle:
  - Occupancy is unchanged. When full, the push succeeds because the pop frees an entry.
  - When empty, a push and a pop cannot coincide: the pop requires non-empty in the previous state.
- tx_en cleared mid-frame: the current frame completes, then the FSM goes to IDLE; the FIFO is retained.
- tx_irq is registered; it asserts the cycle after the condition becomes true.
- Synchronous rst mid-frame:
  - Aborts immediately: txd = 1 next cycle, FIFO flushed, all registers to their reset values.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - CTRL bit2 = parity_en, bit3 = odd.
  - When parity_en = 1, a PARITY state follows DATA for one bit period, sending the even (odd = 0) or odd (odd = 1) parity of the latched byte.
  - Frame = 11 bit periods.
- Undefined:
  - CTRL bits 3:2 read 0 and writes to them are ignored.
  - No PARITY state exists; frame is always 10 bit periods.

Decomposition:
- Shared package mio_uart_pkg:
  - Register offset constants (UART_DATA = 2'd0, UART_STATUS, UART_DIV, UART_CTRL).
  - STATUS bit positions.
  - FSM state encoding (3-bit localparams IDLE/START/DATA/PARITY/STOP).
- One sub-module: sync_fifo.
  - Parameterised width/depth, with push/pop/full/empty/count.
  - Synchronous rst.
  - Push-when-full with a simultaneous pop is accepted.
- The top holds the register file, baud counter and shifter FSM.

Test Plan:
- Reset, no writes → txd = 1 for 1000 cycles; STATUS reads 0x00000002 (empty); DIVISOR reads 433.
- DIV = 3, CTRL = 1, write DATA = 0x55:
  - txd low 4 cycles starting 2 cycles after the write.
  - Then 1,0,1,0,1,0,1,0 at 4 cycles each, then 4 high cycles.
  - busy = 1 throughout the frame.
- DIV = 0, CTRL = 0, write 9 bytes 0x01..0x09:
  - count = 8, full = 1, overflow = 1.
  - Write STATUS → overflow = 0.
  - CTRL = 1 → bytes 0x01..0x08 go out back-to-back, 10 cycles each, with no idle gap.
- CTRL = 3, DIV = 1, one byte:
  - tx_irq = 0 during the frame.
  - tx_irq rises 1 cycle after STOP ends; CTRL = 1 drops it the next cycle.
- Write DIV = 7 during a DIV = 1 frame → current frame stays at 2 cycles/bit; the next frame uses 8 cycles/bit.
- With UART_TX_PARITY_EN, CTRL = 0x5, byte 0x07 → parity bit = 1 (three ones, even parity); frame = 11 bit periods. Assert rst mid-frame → txd = 1 the next cycle; STATUS = 0x2.
